// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack port and
// holds each word on a valid/ready port to the decoder, redirecting on jump/branch.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        jump,
  input  logic [25:0] jump_immediate,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  output logic [31:0] inst_count,
  output logic [1:0]  state_dbg
);

  // Handshakes: a memory transfer completes in the cycle imem_ack is high while
  // imem_req is high; a decoder handoff completes on any edge where
  // inst_valid & inst_ready are both high. Neither side may retract data early.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  state_t      state, state_n;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] next_pc;
  logic        handoff;

  assign handoff   = (state == HOLD) && inst_ready;
  assign imem_addr = pc;
  assign state_dbg = state;

  // Jump keeps the upper nibble of pc+4; branch offsets are word counts.
  always_comb begin
    pc4 = pc + 32'd4;
    if (jump)
      next_pc = {pc4[31:28], jump_immediate, 2'b00};
    else if (branch_taken)
      next_pc = pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    else
      next_pc = pc4;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (fetch_en) state_n = FETCH;
      FETCH:   if (imem_ack) state_n = HOLD;
      HOLD:    if (inst_ready) state_n = fetch_en ? FETCH : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // imem_req and inst_valid are exactly "next state is FETCH / HOLD", registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC_W;
      imem_req    <= 1'b0;
      inst_valid  <= 1'b0;
      instruction <= 32'h0;
      inst_pc     <= 32'h0;
      inst_count  <= 32'h0;
    end else begin
      imem_req   <= (state_n == FETCH);
      inst_valid <= (state_n == HOLD);
      if (state == FETCH && imem_ack) begin
        instruction <= imem_rdata;
        inst_pc     <= pc;
      end
      if (handoff) begin
        pc         <= next_pc;
        inst_count <= inst_count + 32'd1;
      end
    end
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage for the single-issue MIPS-subset core. It owns the program counter and issues word fetches to instruction memory over a req/ack handshake. Each returned word is held on a valid/ready interface to the instruction decoder. On every handoff it takes the decoder's `jump`/`jump_immediate` and the execute stage's branch result to select the next PC.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset; bits [1:0] forced to 00.
- `clk` input 1 — rising-edge clock.
- `rst_n` input 1 — synchronous, active-low reset.
- `fetch_en` input 1 — permits new fetches; low parks the unit in IDLE.
- `imem_req` output 1 — fetch request, registered.
- `imem_addr` output 32 — word address of request (= pc), registered, stable while `imem_req`=1.
- `imem_ack` input 1 — single-cycle pulse; `imem_rdata` is valid in the same cycle.
- `imem_rdata` input 32 — fetched instruction word.
- `inst_valid` output 1 — `instruction`/`inst_pc` hold a fetched word.
- `instruction` output 32 — word to decoder.
- `inst_pc` output 32 — address of `instruction`.
- `inst_ready` input 1 — decoder accepts; handoff = `inst_valid` & `inst_ready`.
- `jump` input 1 — sampled at handoff; J-type redirect.
- `jump_immediate` input 26 — J target field, sampled at handoff.
- `branch_taken` input 1 — sampled at handoff; beq taken.
- `branch_offset` input 16 — beq immediate, sampled at handoff.
- `inst_count` output 32 — number of handoffs since reset.

## Operation
- States: IDLE, FETCH, HOLD.
- Reset (`rst_n`=0 at an edge):
  - state=IDLE, pc=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `inst_valid`=0, `instruction`=0, `inst_pc`=0, `inst_count`=0.
- IDLE:
  - `fetch_en`=1 → FETCH, `imem_req`←1, `imem_addr`←pc.
  - Otherwise stay. `imem_ack` is ignored.
- FETCH:
  - `imem_req` stays 1 and `imem_addr` stays constant until `imem_ack`.
  - On ack: `instruction`←`imem_rdata`, `inst_pc`←pc, `inst_valid`←1, `imem_req`←0 → HOLD.
  - `fetch_en` is not sampled in FETCH; an outstanding request always completes.
- HOLD:
  - `instruction`/`inst_pc` stay stable while `inst_ready`=0.
  - At handoff: `inst_valid`←0, `inst_count`←`inst_count`+1 (wraps 2^32−1→0), pc←next_pc.
  - Then: `fetch_en`=1 → FETCH with `imem_req`←1, `imem_addr`←next_pc; else → IDLE.
  - `imem_ack` is ignored.
- next_pc, with pc4 = pc+4 (mod 2^32):
  - `jump`=1: {pc4[31:28], `jump_immediate`, 2'b00}. Jump has priority over branch.
  - else `branch_taken`=1: pc4 + (sign_extend(`branch_offset`) << 2), mod 2^32.
  - else: pc4.
- `jump`, `branch_taken`, and the offsets are don't-care outside the handoff cycle.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Reset release:
  - First edge with `rst_n`=1 and `fetch_en`=1 → `imem_req`=1 in the following cycle.
- Fetch latency:
  - Ack sampled at edge N → `inst_valid`=1 after edge N.
  - Ack is legal in the first request cycle (zero wait states).
- Handoff:
  - Handoff at edge M → `inst_valid`=0 and `imem_req`=1 with the new address after edge M.
  - Peak throughput is 1 instruction per 2 cycles.
- Reset mid-operation:
  - Reset during FETCH drops `imem_req` at that edge.
  - A late `imem_ack` arriving in IDLE is ignored and does not change pc, `instruction` or `inst_valid`.
- Address boundaries:
  - pc=32'hFFFF_FFFC sequential → 32'h0000_0000.
  - Branch results wrap mod 2^32.

## Test plan
- Reset and zero-wait fetch:
  - Hold `rst_n`=0 3 cycles → all outputs at reset values.
  - Release with `fetch_en`=1, memory acks in the same cycle, `inst_ready`=1.
  - Required: `imem_addr` sequence 0,4,8,12; `inst_count`=4 after 4 handoffs; `inst_valid` alternates.
- Wait states and backpressure:
  - Memory acks 3 cycles after req; `inst_ready` held low 5 cycles in HOLD.
  - Required: `imem_addr` stable throughout the wait; `instruction` stable throughout; no new req until handoff.
- Jump:
  - At pc=32'h1000_0040, handoff with `jump`=1, `jump_immediate`=26'h000_0100, `branch_taken`=1.
  - Required: next `imem_addr`=32'h1000_0400 (jump wins over branch).
- Branch backward and wrap:
  - pc=32'h0000_0020, `branch_taken`=1, `branch_offset`=16'hFFF8 → next `imem_addr`=32'h0000_0004.
  - `RESET_PC`=32'hFFFF_FFFC sequential → 32'h0000_0000.
- fetch_en halt:
  - Drop `fetch_en` while in HOLD; hand off.
  - Required: state IDLE, `imem_req`=0, pc=next_pc.
  - Raise `fetch_en` → req at next_pc one cycle later.
- Reset mid-fetch:
  - Assert `rst_n`=0 during an outstanding req; deliver `imem_ack` with 32'hDEAD_BEEF the cycle after release while `fetch_en`=0.
  - Required: `imem_req`=0, `inst_valid`=0, `instruction`=0, pc=`RESET_PC`.
